// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/lap/clear FSM and a six-digit
// MM:SS.cc BCD counter advanced by base_tick rising edges.
module stopwatch_ctrl #(
  parameter int MIN_LIMIT = 59
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        base_tick,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic        timer_enb,
  output logic [23:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        rollover
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE
  } state_e;

  localparam logic [3:0] MIN_T_MAX = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] MIN_U_MAX = 4'(MIN_LIMIT % 10);
  localparam logic [23:0] LIVE_MAX =
    {MIN_T_MAX, MIN_U_MAX, 16'h5999};
  // Value at which each digit wraps and carries onward.
  localparam logic [23:0] DIGIT_MAX = 24'h995999;

  state_e      state_q, state_d;
  logic        tick_q;
  logic [23:0] live_q, live_d;
  logic [23:0] lap_q, lap_d;
  logic        rollover_q, rollover_d;
  logic        run_q, run_d;
  logic        lapa_q, lapa_d;
  logic        tick;
  logic        counting;
  logic        carry;

  assign tick     = base_tick & ~tick_q;
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_IDLE;
    end else if (start_stop) begin
      unique case (state_q)
        S_IDLE:  state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_LAP:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end else if (lap) begin
      unique case (state_q)
        S_RUN:   state_d = S_LAP;
        S_LAP:   state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
    run_d  = (state_d == S_RUN) || (state_d == S_LAP);
    lapa_d = (state_d == S_LAP);
  end

  always_comb begin
    live_d     = live_q;
    lap_d      = lap_q;
    rollover_d = 1'b0;
    carry      = 1'b1;
    if (clear) begin
      live_d = '0;
      lap_d  = '0;
    end else begin
      // Snapshot uses the pre-increment live value.
      if (state_q == S_RUN && state_d == S_LAP)
        lap_d = live_q;
      if (tick && counting) begin
        if (live_q == LIVE_MAX) begin
          live_d     = '0;
          rollover_d = 1'b1;
        end else begin
          for (int i = 0; i < 6; i++) begin
            if (carry) begin
              if (live_q[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
                live_d[4*i +: 4] = 4'd0;
              end else begin
                live_d[4*i +: 4] = live_q[4*i +: 4] + 4'd1;
                carry = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tick_q     <= 1'b0;
      live_q     <= '0;
      lap_q      <= '0;
      rollover_q <= 1'b0;
      run_q      <= 1'b0;
      lapa_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= base_tick;
      live_q     <= live_d;
      lap_q      <= lap_d;
      rollover_q <= rollover_d;
      run_q      <= run_d;
      lapa_q     <= lapa_d;
    end
  end

  assign timer_enb  = run_q;
  assign running    = run_q;
  assign lap_active = lapa_q;
  assign rollover   = rollover_q;
  assign disp_bcd   = lapa_q ? lap_q : live_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: two instances (MIN_LIMIT 59 and 1) checked
// against a centisecond-count model plus vector table and sequences.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bt, ss, lp, clr;
  logic        enb [2];
  logic [23:0] disp [2];
  logic        run [2];
  logic        lapa [2];
  logic        roll [2];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.MIN_LIMIT(59)) u_d0 (
    .sys_clk(clk), .reset_n(rst_n), .base_tick(bt),
    .start_stop(ss), .lap(lp), .clear(clr),
    .timer_enb(enb[0]), .disp_bcd(disp[0]), .running(run[0]),
    .lap_active(lapa[0]), .rollover(roll[0])
  );

  stopwatch_ctrl #(.MIN_LIMIT(1)) u_d1 (
    .sys_clk(clk), .reset_n(rst_n), .base_tick(bt),
    .start_stop(ss), .lap(lp), .clear(clr),
    .timer_enb(enb[1]), .disp_bcd(disp[1]), .running(run[1]),
    .lap_active(lapa[1]), .rollover(roll[1])
  );

  // Model: elapsed time as plain centiseconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;
  int m_st;
  int m_prev;
  int m_cnt [2];
  int m_lap [2];
  int m_roll [2];
  int m_mod [2] = '{60 * 6000, 2 * 6000};

  function automatic logic [23:0] to_bcd(int x);
    int m, s, c;
    m = x / 6000;
    s = (x / 100) % 60;
    c = x % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10),
            4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_IDLE;
    m_prev = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0;
      m_lap[k] = 0;
      m_roll[k] = 0;
    end
  endtask

  task automatic model_step(int b, int s, int l, int c);
    int tk, nst;
    tk = (b == 1 && m_prev == 0) ? 1 : 0;
    m_prev = b;
    if (c == 1) begin
      m_st = M_IDLE;
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] = 0;
        m_lap[k] = 0;
        m_roll[k] = 0;
      end
    end else begin
      nst = m_st;
      if (s == 1)
        nst = (m_st == M_IDLE || m_st == M_PAUSE) ? M_RUN : M_PAUSE;
      else if (l == 1 && m_st == M_RUN)
        nst = M_LAP;
      else if (l == 1 && m_st == M_LAP)
        nst = M_RUN;
      for (int k = 0; k < 2; k++) begin
        m_roll[k] = 0;
        if (m_st == M_RUN && nst == M_LAP)
          m_lap[k] = m_cnt[k];
        if (tk == 1 && (m_st == M_RUN || m_st == M_LAP)) begin
          m_cnt[k] = m_cnt[k] + 1;
          if (m_cnt[k] == m_mod[k]) begin
            m_cnt[k] = 0;
            m_roll[k] = 1;
          end
        end
      end
      m_st = nst;
    end
  endtask

  task automatic check_model(string tag);
    logic act, la;
    act = (m_st == M_RUN || m_st == M_LAP);
    la = (m_st == M_LAP);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_disp"}, 32'(disp[k]),
          32'(la ? to_bcd(m_lap[k]) : to_bcd(m_cnt[k])));
      chk({tag, "_run"}, 32'(run[k]), 32'(act));
      chk({tag, "_enb"}, 32'(enb[k]), 32'(act));
      chk({tag, "_lapa"}, 32'(lapa[k]), 32'(la));
      chk({tag, "_roll"}, 32'(roll[k]), 32'(m_roll[k]));
    end
  endtask

  task automatic step(int b, int s, int l, int c, string tag);
    @(negedge clk);
    bt = b[0]; ss = s[0]; lp = l[0]; clr = c[0];
    @(posedge clk);
    model_step(b, s, l, c);
    #1;
    check_model(tag);
  endtask

  task automatic ticks(int n, string tag);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, tag);
      step(0, 0, 0, 0, tag);
    end
  endtask

  typedef struct {
    logic        b, s, l, c;
    logic [23:0] disp;
    logic        run;
    logic        lapa;
  } vec_t;

  vec_t vt [14];

  initial begin
    vt[0]  = '{0, 1, 0, 0, 24'h000000, 1, 0};
    vt[1]  = '{1, 0, 0, 0, 24'h000001, 1, 0};
    vt[2]  = '{0, 0, 0, 0, 24'h000001, 1, 0};
    vt[3]  = '{1, 0, 0, 0, 24'h000002, 1, 0};
    vt[4]  = '{1, 0, 1, 0, 24'h000002, 1, 1};
    vt[5]  = '{0, 0, 0, 0, 24'h000002, 1, 1};
    vt[6]  = '{1, 0, 0, 0, 24'h000002, 1, 1};
    vt[7]  = '{0, 0, 1, 0, 24'h000003, 1, 0};
    vt[8]  = '{1, 1, 1, 0, 24'h000004, 0, 0};
    vt[9]  = '{0, 0, 0, 0, 24'h000004, 0, 0};
    vt[10] = '{1, 0, 0, 0, 24'h000004, 0, 0};
    vt[11] = '{1, 1, 0, 0, 24'h000004, 1, 0};
    vt[12] = '{0, 1, 0, 1, 24'h000000, 0, 0};
    vt[13] = '{1, 0, 1, 0, 24'h000000, 0, 0};

    rst_n = 1'b0;
    bt = 0; ss = 0; lp = 0; clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_disp", 32'(disp[k]), 32'h0);
      chk("rst_run", 32'(run[k]), 32'h0);
      chk("rst_enb", 32'(enb[k]), 32'h0);
      chk("rst_lapa", 32'(lapa[k]), 32'h0);
      chk("rst_roll", 32'(roll[k]), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(int'(vt[i].b), int'(vt[i].s), int'(vt[i].l),
           int'(vt[i].c), "vec");
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("vec%0d_disp", i), 32'(disp[k]), 32'(vt[i].disp));
        chk($sformatf("vec%0d_run", i), 32'(run[k]), 32'(vt[i].run));
        chk($sformatf("vec%0d_lapa", i), 32'(lapa[k]), 32'(vt[i].lapa));
      end
    end

    step(0, 0, 0, 1, "clr");
    step(0, 1, 0, 0, "go150");
    ticks(150, "go150");
    chk("cnt150", 32'(disp[0]), 32'h000150);
    chk("enb150", 32'(enb[0]), 32'h1);

    step(0, 0, 0, 1, "clr");
    step(0, 1, 0, 0, "pre");
    ticks(5999, "pre");
    chk("pre5999", 32'(disp[0]), 32'h005999);
    ticks(1, "min");
    chk("min_carry0", 32'(disp[0]), 32'h010000);
    chk("min_carry1", 32'(disp[1]), 32'h010000);
    ticks(5999, "pre2");
    chk("pre15999", 32'(disp[1]), 32'h015999);
    step(1, 0, 0, 0, "wrap");
    chk("wrap_disp1", 32'(disp[1]), 32'h000000);
    chk("wrap_roll1", 32'(roll[1]), 32'h1);
    chk("wrap_disp0", 32'(disp[0]), 32'h020000);
    chk("wrap_roll0", 32'(roll[0]), 32'h0);
    step(0, 0, 0, 0, "wrap");
    chk("wrap_roll_end", 32'(roll[1]), 32'h0);

    step(0, 0, 0, 1, "clr");
    step(0, 1, 0, 0, "lap");
    ticks(10, "lap");
    step(0, 0, 1, 0, "lap");
    ticks(5, "lap");
    chk("lap_frozen", 32'(disp[0]), 32'h000010);
    chk("lap_active", 32'(lapa[0]), 32'h1);
    step(0, 0, 1, 0, "lap");
    chk("lap_release", 32'(disp[0]), 32'h000015);

    step(0, 0, 0, 1, "clr");
    step(0, 1, 0, 0, "pause");
    ticks(7, "pause");
    step(0, 1, 0, 0, "pause");
    chk("pause_enb", 32'(enb[0]), 32'h0);
    ticks(3, "pause");
    chk("pause_hold", 32'(disp[0]), 32'h000007);
    step(0, 1, 0, 0, "pause");
    ticks(1, "pause");
    chk("pause_resume", 32'(disp[0]), 32'h000008);

    step(0, 0, 0, 1, "clr");
    step(0, 1, 0, 0, "prio");
    ticks(1234, "prio");
    chk("prio_pre", 32'(disp[0]), 32'h001234);
    step(0, 1, 0, 1, "prio");
    chk("prio_clr_disp", 32'(disp[0]), 32'h000000);
    chk("prio_clr_run", 32'(run[0]), 32'h0);
    step(0, 1, 0, 0, "prio");
    step(0, 1, 1, 0, "prio");
    chk("prio_ss_run", 32'(run[0]), 32'h0);
    chk("prio_ss_lapa", 32'(lapa[0]), 32'h0);

    step(0, 0, 0, 1, "clr");
    step(0, 1, 0, 0, "arst");
    ticks(321, "arst");
    step(0, 0, 1, 0, "arst");
    chk("arst_pre", 32'(disp[0]), 32'h000321);
    #2;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("arst_disp", 32'(disp[k]), 32'h0);
      chk("arst_run", 32'(run[k]), 32'h0);
      chk("arst_enb", 32'(enb[k]), 32'h0);
      chk("arst_lapa", 32'(lapa[k]), 32'h0);
      chk("arst_roll", 32'(roll[k]), 32'h0);
    end
    model_reset();
    @(negedge clk);
    bt = 0; ss = 0; lp = 0; clr = 0;
    rst_n = 1'b1;
    step(1, 0, 1, 0, "post_rst");
    chk("post_rst_idle", 32'(run[0]), 32'h0);
    step(0, 1, 0, 0, "post_rst");
    chk("post_rst_run", 32'(run[0]), 32'h1);

    for (int i = 0; i < 3000; i++) begin
      step(int'($urandom_range(0, 1)),
           ($urandom_range(0, 19) == 0) ? 1 : 0,
           ($urandom_range(0, 19) == 0) ? 1 : 0,
           ($urandom_range(0, 99) == 0) ? 1 : 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch control and time-keeping block; consumes the `base_tick` square wave from the tick timer and drives its `timer_enb`. It counts elapsed time as six BCD digits, minutes, seconds and centiseconds (MM:SS.cc), one centisecond per `base_tick` rising edge. It implements start/stop, lap (display freeze) and clear controls from debounced button pulses. It sits between the timer and the seven-segment display driver.

## Interface
- `MIN_LIMIT`, default 59: highest minutes value, decimal 1..99. The count wraps after MIN_LIMIT:59.99.

- `sys_clk`  in  1  system clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `base_tick`  in  1  square wave from the timer, same clock domain; each rising edge is one centisecond.
- `start_stop`  in  1  single-cycle pulse; toggles run/pause.
- `lap`  in  1  single-cycle pulse; freezes or releases the display.
- `clear`  in  1  single-cycle pulse; zeroes the count and returns to idle.
- `timer_enb`  out  1  enable to the timer; high in RUN and LAP.
- `disp_bcd`  out  24  {min_t, min_u, sec_t, sec_u, cs_t, cs_u}, 4 bits each.
- `running`  out  1  high in RUN and LAP.
- `lap_active`  out  1  high in LAP.
- `rollover`  out  1  one-cycle pulse on wrap to 00:00.00.

## Operation
- Tick detect:
  - `tick_q` registers `base_tick` every cycle.
  - `tick = base_tick & ~tick_q`.
  - Falling edges are ignored.
- Live counter: six BCD digits, incremented by one centisecond on `tick` only while in RUN or LAP.
- Carry chain:
  - cs_u 9→0 carries to cs_t.
  - cs_t 9→0 carries to sec_u.
  - sec_u 9→0 carries to sec_t.
  - sec_t 5→0 carries to min_u.
  - min_u 9→0 carries to min_t.
- Wrap: when the live value is MIN_LIMIT:59.99 and `tick` arrives, all digits go to 0 and `rollover` pulses. Counting continues.
- Digit range: no digit ever holds a value above 9. sec_t never holds a value above 5.
- Lap register:
  - Loads the live value on entry to LAP.
  - If `tick` occurs on the entry edge, it loads the pre-increment value.
- `disp_bcd` is the lap register when `lap_active` is high, otherwise the live counter. This mux is combinational from registers.
- FSM states: IDLE, RUN, LAP, PAUSE.
  - IDLE: `start_stop` → RUN. `lap` is ignored.
  - RUN: `start_stop` → PAUSE. `lap` → LAP.
  - LAP: counting continues and the display is frozen. `lap` → RUN, and the display snaps to the live value. `start_stop` → PAUSE, and the display is released.
  - PAUSE: `start_stop` → RUN. `lap` is ignored.
  - Any state: `clear` → IDLE, the live and lap registers are zeroed, and `rollover` is forced low.
- Simultaneous pulses: priority is `clear` > `start_stop` > `lap`. The losing pulses are dropped, not queued.
- `clear` coincident with `tick`: `clear` wins and the count becomes 00:00.00.
- A `tick` in IDLE or PAUSE is discarded. Resuming does not replay it.

## Timing
- Reset (async assert, any time including mid-count):
  - state = IDLE, `tick_q` = 0, live = lap = 0.
  - `timer_enb` = 0, `running` = 0, `lap_active` = 0, `rollover` = 0.
  - `disp_bcd` = 24'h000000.
- After reset deassertion, the first `tick` can only follow a `base_tick` low→high transition seen after reset.
- Control latency:
  - A pulse sampled at posedge N changes state at edge N.
  - `timer_enb`, `running` and `lap_active` are registered and reflect the new state after edge N.
- Tick latency:
  - If `base_tick` rises before posedge N, the live count increments at edge N.
  - `disp_bcd` shows the new value after edge N, unless in LAP.
- `rollover` is high for exactly the one cycle following the wrap edge.
- The timer may stop mid-period when `timer_enb` falls. `base_tick` state is held by the timer, so no spurious edge occurs on resume.

## Test plan
- Reset then `start_stop`, followed by 150 `base_tick` rising edges → `disp_bcd` = 24'h000150 (00:01.50), `timer_enb` = 1.
- Preload 00:59.99 by ticking, then one tick → 24'h010000. With MIN_LIMIT = 1, preload 01:59.99, then one tick → 24'h000000 and `rollover` high for 1 cycle.
- Lap sequence:
  - In RUN at 00:00.10, pulse `lap`, then 5 ticks → `disp_bcd` stays 24'h000010, `lap_active` = 1.
  - Pulse `lap` → `disp_bcd` = 24'h000015.
- Pause sequence:
  - `start_stop` at 00:00.07 → PAUSE, `timer_enb` = 0.
  - 3 forced `base_tick` edges → count stays 24'h000007.
  - `start_stop` then 1 tick → 24'h000008.
- Priority checks:
  - `clear` and `start_stop` in the same cycle from RUN at 00:12.34 → IDLE, 24'h000000.
  - `start_stop` and `lap` in the same cycle from RUN → PAUSE, `lap_active` = 0.
- Assert `reset_n` low asynchronously (mid-cycle) while in LAP at 00:03.21 → all outputs 0 immediately, and after release the state is IDLE.
